fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one instruction-memory read at a time and
// presents the returned word, its address and address+4 to the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] pc_four,
  output logic        br_sel,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OUT_KEEP   = 2'd0,
    OUT_BUBBLE = 2'd1,
    OUT_MEM    = 2'd2,
    OUT_BUF    = 2'd3
  } out_sel_e;

  state_e      state_q, state_d;
  out_sel_e    out_sel;
  logic [31:0] pc_r;
  logic [31:0] fetch_pc;
  logic [31:0] buf_ins;
  logic [31:0] buf_pc;
  logic        discard_q, discard_d;
  logic        active_q;
  logic        fetch_fire;
  logic        rsp_live;
  logic        buf_load;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic (FSM and discard flag)
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is assigned a default before any branch,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    if (redirect_i) begin
      state_d = REQ;
      // A fetch still in flight after this edge must have its data dropped.
      discard_d = fetch_fire
               || (state_q == WAIT && !imem_rvalid_i)
               || (discard_q && !imem_rvalid_i);
    end else begin
      if (discard_q && imem_rvalid_i) begin
        discard_d = 1'b0;
      end
      case (state_q)
        REQ:     if (fetch_fire) state_d = WAIT;
        WAIT:    if (rsp_live)   state_d = stall_i ? HOLD : REQ;
        HOLD:    if (!stall_i)   state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req_o = active_q && (state_q == REQ) && !discard_q;
    fetch_fire = imem_req_o && imem_gnt_i;
    rsp_live   = imem_rvalid_i && (state_q == WAIT) && !discard_q;
    buf_load   = 1'b0;
    out_sel    = OUT_KEEP;
    if (redirect_i) begin
      out_sel = OUT_BUBBLE;
    end else if (!stall_i) begin
      if (rsp_live) begin
        out_sel = OUT_MEM;
      end else if (state_q == HOLD) begin
        out_sel = OUT_BUF;
      end else begin
        out_sel = OUT_BUBBLE;
      end
    end else if (rsp_live) begin
      buf_load = 1'b1;
    end
  end

  assign imem_addr_o = pc_r;

  // ---------------------------------------------------------------------------
  // Fetch address, in-flight bookkeeping
  // ---------------------------------------------------------------------------
  // active_q keeps the request low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r      <= RESET_PC;
      fetch_pc  <= 32'h0000_0000;
      discard_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      active_q  <= 1'b1;
      discard_q <= discard_d;
      if (redirect_i) begin
        pc_r <= redirect_pc_i & ~32'd3;
      end else if (fetch_fire) begin
        pc_r <= pc_r + 32'd4;
      end
      if (fetch_fire) begin
        fetch_pc <= pc_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One-entry skid buffer for words returning during a stall
  // ---------------------------------------------------------------------------
  // NOTE: the buffer payload has no reset; its occupancy is the HOLD state,
  // which is reset, so stale contents can never be presented.
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_ins <= imem_rdata_i;
      buf_pc  <= fetch_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ins     <= NOP_INS;
      pc      <= 32'h0000_0000;
      pc_four <= 32'h0000_0000;
      valid_o <= 1'b0;
      br_sel  <= 1'b0;
    end else begin
      case (out_sel)
        OUT_BUBBLE: begin
          ins     <= NOP_INS;
          valid_o <= 1'b0;
          br_sel  <= redirect_i;
        end
        OUT_MEM: begin
          ins     <= imem_rdata_i;
          pc      <= fetch_pc;
          pc_four <= fetch_pc + 32'd4;
          valid_o <= 1'b1;
          br_sel  <= 1'b0;
        end
        OUT_BUF: begin
          ins     <= buf_ins;
          pc      <= buf_pc;
          pc_four <= buf_pc + 32'd4;
          valid_o <= 1'b1;
          br_sel  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level memory and reference
// model push expected per-cycle outputs; a monitor pops and compares them.
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] ins, pc, pc_four;
  logic        br_sel, valid_o;

  fetch_unit #(.RESET_PC(TB_RESET_PC), .NOP_INS(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .ins           (ins),
    .pc            (pc),
    .pc_four       (pc_four),
    .br_sel        (br_sel),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic        valid;
    logic        br;
    logic        req;
    logic [31:0] addr;
  } snap_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } instr_t;

  snap_t  sb[$];
  instr_t pend[$];
  snap_t  cur;

  int checks = 0;
  int errors = 0;
  int dut_deliv = 0;

  // memory / model state
  bit          m_active;
  logic [31:0] m_addr;
  bit          mem_busy, mem_stale;
  int          mem_lat;
  logic [31:0] mem_pc, mem_data;
  int          gnt_pct = 100;
  int          lat_lo = 0, lat_hi = 0;
  bit          seq_data = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one expected output snapshot per clock edge.
  always @(posedge clk) begin
    logic [31:0] gpc;
    bit          rv_fresh;
    instr_t      x;
    if (!rst) begin
      pend.delete();
      m_active  = 1'b0;
      m_addr    = TB_RESET_PC;
      mem_busy  = 1'b0;
      mem_stale = 1'b0;
      mem_lat   = 0;
      cur = '{ins: NOP, pc: 32'h0, pc_four: 32'h0, valid: 1'b0, br: 1'b0,
              req: 1'b0, addr: TB_RESET_PC};
    end else begin
      gpc      = m_addr;
      rv_fresh = imem_rvalid_i && mem_busy && !mem_stale;
      if (imem_rvalid_i) mem_busy = 1'b0;
      else if (mem_busy && mem_lat > 0) mem_lat--;
      if (redirect_i) begin
        pend.delete();
        cur.ins   = NOP;
        cur.valid = 1'b0;
        cur.br    = 1'b1;
        if (mem_busy) mem_stale = 1'b1;
        m_addr = redirect_pc_i & ~32'd3;
      end else begin
        if (rv_fresh) pend.push_back('{pc: mem_pc, ins: mem_data});
        if (!stall_i) begin
          if (pend.size() > 0) begin
            x = pend.pop_front();
            cur.ins     = x.ins;
            cur.pc      = x.pc;
            cur.pc_four = x.pc + 32'd4;
            cur.valid   = 1'b1;
          end else begin
            cur.ins   = NOP;
            cur.valid = 1'b0;
          end
          cur.br = 1'b0;
        end
      end
      if (imem_gnt_i) begin
        mem_busy  = 1'b1;
        mem_stale = redirect_i;
        mem_pc    = gpc;
        mem_data  = seq_data ? 32'hA0 + gpc : $urandom;
        mem_lat   = $urandom_range(lat_lo, lat_hi);
        if (!redirect_i) m_addr = gpc + 32'd4;
      end
      m_active = 1'b1;
      cur.req  = m_active && !mem_busy && (pend.size() == 0);
      cur.addr = m_addr;
    end
    sb.push_back(cur);
  end

  // Instruction memory driver.
  always @(negedge clk) begin
    imem_gnt_i    = imem_req_o && rst && !mem_busy && ($urandom_range(0, 99) < gnt_pct);
    imem_rvalid_i = mem_busy && (mem_lat == 0) && rst;
    imem_rdata_i  = imem_rvalid_i ? mem_data : $urandom;
  end

  // Monitor.
  always @(negedge clk) begin
    snap_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ins", ins, e.ins);
      check("pc", pc, e.pc);
      check("pc_four", pc_four, e.pc_four);
      check("valid_o", 32'(valid_o), 32'(e.valid));
      check("br_sel", 32'(br_sel), 32'(e.br));
      check("imem_req_o", 32'(imem_req_o), 32'(e.req));
      if (e.req) check("imem_addr_o", imem_addr_o, e.addr);
      if (e.valid && valid_o) dut_deliv++;
    end
  end

  task automatic wait_busy(input int want_lat, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (mem_busy && mem_lat == want_lat) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] got_pc[4], got_ins[4], got_pf[4];
    logic [31:0] exp_pc[4], exp_ins[4], exp_pf[4];
    int  n;
    bit  prev_v;
    bit  seen;

    exp_pc  = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    exp_ins = '{32'h0000_009C, 32'hA0, 32'hA4, 32'hA8};
    exp_pf  = '{32'h0, 32'h4, 32'h8, 32'hC};

    // Reset and first fetches with a single-cycle memory, address wraps to 0.
    repeat (3) @(negedge clk);
    #1;
    check("reset_ins", ins, NOP);
    check("reset_req", 32'(imem_req_o), 32'd0);
    #1 rst = 1'b1;
    n = 0;
    prev_v = 1'b0;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      @(negedge clk);
      #1;
      if (valid_o && !prev_v) begin
        got_pc[n] = pc; got_ins[n] = ins; got_pf[n] = pc_four;
        n++;
      end
      prev_v = valid_o;
    end
    check("first_fetch_count", 32'(n), 32'd4);
    for (int i = 0; i < n; i++) begin
      check($sformatf("first_pc%0d", i), got_pc[i], exp_pc[i]);
      check($sformatf("first_ins%0d", i), got_ins[i], exp_ins[i]);
      check($sformatf("first_pc_four%0d", i), got_pf[i], exp_pf[i]);
    end

    // Redirect while waiting for data; stale response must be dropped.
    lat_lo = 2; lat_hi = 2;
    wait_busy(2, "redirect_wait");
    redirect_i = 1'b1;
    redirect_pc_i = 32'h103;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    check("redir_br_sel", 32'(br_sel), 32'd1);
    check("redir_valid", 32'(valid_o), 32'd0);
    check("redir_ins", ins, NOP);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (imem_req_o) seen = 1'b1;
    end
    check("redir_req_seen", 32'(seen), 32'd1);
    check("redir_addr", imem_addr_o, 32'h100);

    // Word returns under stall, then redirect+stall flushes the buffer.
    lat_lo = 0; lat_hi = 0;
    wait_busy(0, "stall_buffer");
    stall_i = 1'b1;
    @(negedge clk);
    #1;
    check("hold_req", 32'(imem_req_o), 32'd0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    @(negedge clk);
    redirect_i = 1'b0;
    stall_i = 1'b0;
    #1;
    check("flush_br_sel", 32'(br_sel), 32'd1);
    check("flush_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    #1;
    check("flush_no_buffered", 32'(valid_o), 32'd0);
    check("flush_br_clear", 32'(br_sel), 32'd0);

    // Reset asserted while a fetch is outstanding.
    lat_lo = 2; lat_hi = 2;
    wait_busy(2, "reset_wait");
    #2 rst = 1'b0;
    #1;
    check("rst_ins", ins, NOP);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_four", pc_four, 32'h0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_br_sel", 32'(br_sel), 32'd0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Randomised traffic.
    gnt_pct = 70; lat_lo = 0; lat_hi = 3; seq_data = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      stall_i       = ($urandom_range(0, 3) == 0);
      redirect_i    = ($urandom_range(0, 9) == 0);
      redirect_pc_i = $urandom;
    end
    @(negedge clk);
    stall_i = 1'b0;
    redirect_i = 1'b0;
    repeat (10) @(negedge clk);
    check("progress", 32'(dut_deliv > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
